// File: rtl/countdown_timer.sv
// MM:SS countdown timer driven by the upstream tick stream.
// Holds the time in binary; BCD digits, running, done and expired are all registered outputs.
module countdown_timer #(
   parameter int unsigned TICKS_PER_SEC = 1000,
   parameter int unsigned MAX_MIN       = 99
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       load,
   input  logic [6:0] preset_min,
   input  logic [5:0] preset_sec,
   input  logic       start,
   input  logic       pause,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       done,
   output logic       expired
);

   localparam int unsigned     SubW    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [SubW-1:0] SubLast = SubW'(TICKS_PER_SEC - 1);
   localparam logic [6:0]      MaxMin  = 7'(MAX_MIN);
   localparam logic [5:0]      MaxSec  = 6'd59;

   typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

   state_e          state_q, state_d;
   logic [6:0]      min_q, min_d;
   logic [5:0]      sec_q, sec_d;
   logic [SubW-1:0] sub_q, sub_d;
   logic            tick_prev_q;
   logic            tick_rise;
   logic            done_d;
   logic [7:0]      min_bcd_q, sec_bcd_q;
   logic            running_q, done_q, expired_q;

   // Binary 0..99 to two BCD digits {tens, ones}.
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(v / 7'd10);
      ones = 4'(v % 7'd10);
      return {tens, ones};
   endfunction

   assign tick_rise = tick & ~tick_prev_q;

   // Next-state: load has priority over everything; then per-state start/pause/tick handling.
   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      sub_d   = sub_q;
      done_d  = 1'b0;
      if (load) begin
         min_d   = (preset_min > MaxMin) ? MaxMin : preset_min;
         sec_d   = (preset_sec > MaxSec) ? MaxSec : preset_sec;
         sub_d   = '0;
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               // pause wins over a coincident start
               if (start && !pause && (min_q != 7'd0 || sec_q != 6'd0)) state_d = StRun;
            end
            StRun: begin
               // pause freezes immediately; a tick edge in the same cycle is dropped
               if (pause) begin
                  state_d = StPause;
               end else if (tick_rise) begin
                  if (sub_q == SubLast) begin
                     sub_d = '0;
                     if (sec_q != 6'd0) begin
                        sec_d = sec_q - 6'd1;
                     end else if (min_q != 7'd0) begin
                        sec_d = MaxSec;
                        min_d = min_q - 7'd1;
                     end
                     if (min_d == 7'd0 && sec_d == 6'd0) begin
                        state_d = StExpired;
                        done_d  = 1'b1;
                     end
                  end else begin
                     sub_d = sub_q + 1'b1;
                  end
               end
            end
            StPause: begin
               if (start && !pause) state_d = StRun;
            end
            StExpired: begin
               state_d = StExpired;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and registered outputs; BCD is taken from the next value so display has no extra lag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         min_q       <= '0;
         sec_q       <= '0;
         sub_q       <= '0;
         tick_prev_q <= 1'b0;
         min_bcd_q   <= 8'h00;
         sec_bcd_q   <= 8'h00;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         expired_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         sub_q       <= sub_d;
         tick_prev_q <= tick;
         min_bcd_q   <= to_bcd(min_d);
         sec_bcd_q   <= to_bcd({1'b0, sec_d});
         running_q   <= (state_d == StRun);
         done_q      <= done_d;
         expired_q   <= (state_d == StExpired);
      end
   end

   assign min_bcd = min_bcd_q;
   assign sec_bcd = sec_bcd_q;
   assign running = running_q;
   assign done    = done_q;
   assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: time kept as total seconds in a behavioural model,
// checked every cycle, plus directed scenarios with literal expectations.
module tb_countdown_timer;

   localparam int unsigned Tps = 4;

   logic       clk = 1'b0;
   logic       rst, tick, load, start, pause;
   logic [6:0] preset_min;
   logic [5:0] preset_sec;
   logic [7:0] min_bcd, sec_bcd;
   logic       running, done, expired;

   countdown_timer #(.TICKS_PER_SEC(Tps), .MAX_MIN(99)) dut (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .load       (load),
      .preset_min (preset_min),
      .preset_sec (preset_sec),
      .start      (start),
      .pause      (pause),
      .min_bcd    (min_bcd),
      .sec_bcd    (sec_bcd),
      .running    (running),
      .done       (done),
      .expired    (expired)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;
   bit chk_en      = 1'b0;

   // Model: mode 0 idle, 1 run, 2 pause, 3 expired; time as total seconds.
   int m_mode  = 0;
   int m_total = 0;
   int m_sub   = 0;
   bit m_prev  = 1'b0;
   bit m_done  = 1'b0;

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit t, input bit ld, input int pm, input int ps,
                             input bit st, input bit pa, input bit r);
      bit rise;
      if (r) begin
         m_mode = 0; m_total = 0; m_sub = 0; m_prev = 1'b0; m_done = 1'b0;
         return;
      end
      rise   = t && !m_prev;
      m_prev = t;
      m_done = 1'b0;
      if (ld) begin
         m_total = ((pm > 99) ? 99 : pm) * 60 + ((ps > 59) ? 59 : ps);
         m_sub   = 0;
         m_mode  = 0;
      end else begin
         case (m_mode)
            0: if (st && !pa && m_total != 0) m_mode = 1;
            1: begin
               if (pa) m_mode = 2;
               else if (rise) begin
                  m_sub++;
                  if (m_sub == Tps) begin
                     m_sub = 0;
                     m_total--;
                     if (m_total == 0) begin
                        m_mode = 3;
                        m_done = 1'b1;
                     end
                  end
               end
            end
            2: if (st && !pa) m_mode = 1;
            default: ;
         endcase
      end
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("min_bcd", min_bcd, bcd(m_total / 60));
         cmp("sec_bcd", sec_bcd, bcd(m_total % 60));
         cmp("running", {7'd0, running}, {7'd0, (m_mode == 1)});
         cmp("done", {7'd0, done}, {7'd0, m_done});
         cmp("expired", {7'd0, expired}, {7'd0, (m_mode == 3)});
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic step(input bit t, input bit ld, input int pm, input int ps,
                       input bit st, input bit pa, input bit r);
      tick = t; load = ld; preset_min = 7'(pm); preset_sec = 6'(ps);
      start = st; pause = pa; rst = r;
      @(posedge clk);
      model_step(t, ld, pm, ps, st, pa, r);
      #1;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_load(input int pm, input int ps);
      step(0, 1, pm, ps, 0, 0, 0);
   endtask

   task automatic do_start();
      step(0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic do_pause();
      step(0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic pulses(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         idle_n(gap - 1);
      end
   endtask

   // Literal check of the DUT output and of the model's view of it.
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] mdl,
                        input logic [7:0] exp);
      cmp({name, " dut"}, act, exp);
      cmp({name, " model"}, mdl, exp);
   endtask

   initial begin
      int t_lvl;
      step(0, 0, 0, 0, 0, 0, 1);
      chk_en = 1'b1;
      check("reset min", min_bcd, bcd(m_total / 60), 8'h00);
      check("reset sec", sec_bcd, bcd(m_total % 60), 8'h00);
      cmp("reset flags", {5'd0, running, done, expired}, 8'h00);

      // 0:02 countdown to expiry
      do_load(0, 2); do_start();
      done_cnt = 0;
      pulses(4, 10);
      check("t1 sec after 4", sec_bcd, bcd(m_total % 60), 8'h01);
      pulses(4, 10);
      check("t1 sec after 8", sec_bcd, bcd(m_total % 60), 8'h00);
      cmp("t1 expired", {7'd0, expired}, 8'h01);
      cmp("t1 running", {7'd0, running}, 8'h00);
      cmp("t1 done count", 8'(done_cnt), 8'd1);

      // long tick levels count once each
      do_load(0, 5); do_start();
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 50; i++) step(1, 0, 0, 0, 0, 0, 0);
         idle_n(5);
      end
      check("t2 sec", sec_bcd, bcd(m_total % 60), 8'h04);

      // borrow and clamping
      do_load(1, 0); do_start();
      pulses(4, 3);
      check("t3 min", min_bcd, bcd(m_total / 60), 8'h00);
      check("t3 sec", sec_bcd, bcd(m_total % 60), 8'h59);
      do_load(120, 63);
      check("t3 clamp min", min_bcd, bcd(m_total / 60), 8'h99);
      check("t3 clamp sec", sec_bcd, bcd(m_total % 60), 8'h59);

      // pause retains sub
      do_load(0, 3); do_start();
      pulses(2, 4); do_pause(); pulses(6, 4); do_start();
      pulses(1, 4);
      check("t4 sec mid", sec_bcd, bcd(m_total % 60), 8'h03);
      pulses(1, 4);
      check("t4 sec", sec_bcd, bcd(m_total % 60), 8'h02);

      // start with zero, start+pause in idle
      do_load(0, 0);
      done_cnt = 0;
      do_start(); pulses(8, 3);
      cmp("t5 running", {7'd0, running}, 8'h00);
      cmp("t5 done count", 8'(done_cnt), 8'd0);
      do_load(0, 5);
      step(0, 0, 0, 0, 1, 1, 0);
      pulses(8, 3);
      cmp("t5b running", {7'd0, running}, 8'h00);
      check("t5b sec", sec_bcd, bcd(m_total % 60), 8'h05);

      // reset mid-run, then expiry and reload
      do_load(0, 7); do_start(); pulses(2, 3);
      step(0, 0, 0, 0, 0, 0, 1);
      check("t6 rst sec", sec_bcd, bcd(m_total % 60), 8'h00);
      cmp("t6 rst flags", {5'd0, running, done, expired}, 8'h00);
      pulses(8, 3);
      check("t6 idle sec", sec_bcd, bcd(m_total % 60), 8'h00);
      do_load(0, 1); do_start(); pulses(4, 3);
      cmp("t6 expired", {7'd0, expired}, 8'h01);
      do_start(); pulses(4, 3);
      do_load(0, 4);
      cmp("t6 reload expired", {7'd0, expired}, 8'h00);
      check("t6 reload sec", sec_bcd, bcd(m_total % 60), 8'h04);

      // randomized traffic
      t_lvl = 0;
      for (int i = 0; i < 4000; i++) begin
         bit ld, st, pa, r;
         int pm, ps;
         if ($urandom_range(0, 3) == 0) t_lvl = 1 - t_lvl;
         ld = ($urandom_range(0, 149) == 0);
         st = ($urandom_range(0, 19) == 0);
         pa = ($urandom_range(0, 59) == 0);
         r  = ($urandom_range(0, 999) == 0);
         pm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : 0;
         ps = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63))
                                          : int'($urandom_range(0, 6));
         step(t_lvl[0], ld, pm, ps, st, pa, r);
         if (m_mode == 0 && m_total != 0 && $urandom_range(0, 3) == 0) do_start();
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
